// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_pkg
//  Description : Shared state encoding and default sizing for the bit-serial
//                adder controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_cnt_w = 5;

    // Code 2'd3 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_if
//  Description : start/busy/done request bus with operands and result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : Structural one-bit full adder: two half adders and an OR.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);

    logic w_ha0_s;
    logic w_ha0_c;
    logic w_ha1_c;

    assign w_ha0_s = a ^ b;
    assign w_ha0_c = a & b;

    assign s       = w_ha0_s ^ cin;
    assign w_ha1_c = w_ha0_s & cin;

    assign cout    = w_ha0_c | w_ha1_c;

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder; one full-adder cell reused LSB-first over
//                WIDTH cycles behind a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_adder_ctrl_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic [WIDTH-1:0]   w_sum_shifted;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic               w_fa_s;
    logic               w_fa_cout;

    full_adder_bit u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // The cell output enters at the MSB; a single-bit sum has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shifted = w_fa_s;
        end else begin : g_sum_wn
            assign w_sum_shifted = {w_fa_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step      = 1'b1;
                w_state_nxt = w_last ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // Status flags follow the next state so they stay flop outputs.
            r_busy <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_DONE);
            r_done <= (w_state_nxt == ST_DONE);
            if (w_load) begin
                r_a_sh   <= bus.a;
                r_b_sh   <= bus.b;
                r_carry  <= bus.cin;
                r_cnt    <= '0;
                r_sum_sh <= '0;
            end else if (w_step) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_carry  <= w_fa_cout;
                r_sum_sh <= w_sum_shifted;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum  <= w_sum_shifted;
                    r_cout <= w_fa_cout;
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl at WIDTH 1, 8, 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  bus8  ();
    serial_adder_ctrl_if #(.WIDTH(1))  bus1  ();
    serial_adder_ctrl_if #(.WIDTH(32)) bus32 ();

    serial_adder_ctrl #(.WIDTH(8),  .CNT_W(5)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1),  .CNT_W(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder_ctrl #(.WIDTH(32), .CNT_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] res;
    } vec_t;

    vec_t        vt [6];
    logic [32:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 add: busy next cycle, done WIDTH edges after the start edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [8:0] exp, input string name);
        int lat;
        bit seen;
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = ~a; bus8.b = ~b; bus8.cin = ~cin;
        check({name, "_busy"}, 64'(bus8.busy), 64'd1);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 40) begin
            if (bus8.done) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({name, "_lat"}, 64'(lat), 64'd8);
        check({name, "_res"}, 64'({bus8.cout, bus8.sum}), 64'(exp));
        tick();
        check({name, "_pulse"}, 64'(bus8.done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n_done;
        logic [8:0]  got;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [31:0] wa, wb;
        logic [32:0] e;

        vt[0] = '{8'h5A, 8'h33, 1'b0, 9'h08D};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vt[2] = '{8'h00, 8'h00, 1'b1, 9'h001};
        vt[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vt[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
        vt[5] = '{8'h7F, 8'h01, 1'b1, 9'h081};

        bus8.start  = 0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 0;
        bus1.start  = 0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 0;
        bus32.start = 0; bus32.a = '0; bus32.b = '0; bus32.cin = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();
        check("reset_w8",  64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'd0);
        check("reset_w32", 64'({bus32.busy, bus32.done, bus32.cout, bus32.sum}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run8(vt[i].a, vt[i].b, vt[i].cin, vt[i].res, $sformatf("vec%0d", i));

        // Starts raised while busy (SHIFT at edge 3, DONE at edge 9) are dropped.
        bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 0; bus8.start = 1'b1;
        tick();
        n_done = 0;
        got    = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            bus8.start = (cyc == 3 || cyc == 9);
            bus8.a = 8'h01; bus8.b = 8'h01;
            tick();
            if (bus8.done) begin
                n_done++;
                got = {bus8.cout, bus8.sum};
            end
        end
        bus8.start = 1'b0;
        check("ignore_done_count", 64'(n_done), 64'd1);
        check("ignore_res", 64'(got), 64'h08D);

        // Asynchronous reset in the middle of an add.
        bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1 check("midreset_outs", 64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'd0);
        #3 rst_n = 1'b1;
        n_done = 0;
        repeat (15) begin
            tick();
            if (bus8.done) n_done++;
        end
        check("midreset_no_done", 64'(n_done), 64'd0);
        run8(8'h10, 8'h20, 1'b0, 9'h030, "post_reset");

        // Back-to-back with start held high: one accept every 10 edges.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp_q.push_back(33'(ra) + 33'(rb) + 33'(rc));
            bus8.a = ra; bus8.b = rb; bus8.cin = rc; bus8.start = 1'b1;
            tick();
            for (int c = 1; c <= 9; c++) begin
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
                tick();
                if (c == 8) begin
                    check("b2b_w8_done", 64'(bus8.done), 64'd1);
                    e = exp_q.pop_front();
                    check("b2b_w8_res", 64'({bus8.cout, bus8.sum}), 64'(e));
                end else if (c == 9) begin
                    check("b2b_w8_pulse", 64'(bus8.done), 64'd0);
                end
            end
        end
        bus8.start = 1'b0;

        // WIDTH=1: exhaustive over a, b, cin.
        for (int i = 0; i < 8; i++) begin
            bus1.a = 1'(i >> 2); bus1.b = 1'(i >> 1); bus1.cin = 1'(i);
            e = 33'((i >> 2) & 1) + 33'((i >> 1) & 1) + 33'(i & 1);
            bus1.start = 1'b1;
            tick();
            check("w1_busy", 64'(bus1.busy), 64'd1);
            for (int c = 1; c <= 2; c++) begin
                bus1.a = ~bus1.a;
                tick();
                if (c == 1) begin
                    check("w1_done", 64'(bus1.done), 64'd1);
                    check("w1_res", 64'({bus1.cout, bus1.sum}), 64'(e));
                end else begin
                    check("w1_pulse", 64'(bus1.done), 64'd0);
                end
            end
        end
        bus1.start = 1'b0;

        // WIDTH=32: random operands, done 32 edges after the start edge.
        for (int i = 0; i < 40; i++) begin
            wa = $urandom; wb = $urandom; rc = 1'($urandom);
            if (i == 0) begin wa = '1; wb = '1; rc = 1'b1; end
            exp_q.push_back(33'(wa) + 33'(wb) + 33'(rc));
            bus32.a = wa; bus32.b = wb; bus32.cin = rc; bus32.start = 1'b1;
            tick();
            for (int c = 1; c <= 33; c++) begin
                bus32.a = $urandom; bus32.b = $urandom;
                tick();
                if (c == 31) begin
                    check("w32_early", 64'(bus32.done), 64'd0);
                end else if (c == 32) begin
                    check("w32_done", 64'(bus32.done), 64'd1);
                    e = exp_q.pop_front();
                    check("w32_res", 64'({bus32.cout, bus32.sum}), 64'(e));
                end
            end
        end
        bus32.start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
